// File: rtl/data_ram_responder.sv
// Data-side SRAM responder: byte-writable data RAM plus a small MMIO register window.
// Read data is registered and appears one cycle after the request; writes never update it.
module data_ram_responder #(
    parameter int unsigned RAM_ADDRESS_WIDTH = 16,
    parameter logic [31:0] MMIO_BASE         = 32'hbfaf_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        data_ram_enabled,
    input  logic [3:0]  data_ram_write_enabled,
    input  logic [31:0] data_ram_address,
    input  logic [31:0] data_ram_write_data,
    output logic [31:0] data_ram_read_data,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] num_display
);

    localparam int unsigned RamDepth   = 1 << RAM_ADDRESS_WIDTH;
    localparam logic [15:0] OffTimer   = 16'he000;
    localparam logic [15:0] OffLed     = 16'hf000;
    localparam logic [15:0] OffNum     = 16'hf010;
    localparam logic [15:0] OffSwitch  = 16'hf020;
    localparam logic [15:0] OffScratch = 16'hf030;

    // RAM contents are deliberately not reset.
    logic [31:0] mem [RamDepth];

    logic [31:0] timer_q, timer_d;
    logic [15:0] led_q, led_d;
    logic [31:0] num_q, num_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] read_data_q, read_data_d;
    logic [7:0]  sync1_q, sync2_q;

    logic                         mmio_hit;
    logic [15:0]                  offset;
    logic [RAM_ADDRESS_WIDTH-1:0] word_index;
    logic                         is_write;
    logic                         is_read;
    logic [31:0]                  read_mux;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_value,
                                                input logic [31:0] new_value,
                                                input logic [3:0]  mask);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = mask[i] ? new_value[8*i +: 8] : old_value[8*i +: 8];
        end
        return result;
    endfunction

    assign mmio_hit   = (data_ram_address[31:16] == MMIO_BASE[31:16]);
    assign offset     = data_ram_address[15:0];
    assign word_index = data_ram_address[RAM_ADDRESS_WIDTH+1:2];
    assign is_write   = data_ram_enabled && (data_ram_write_enabled != 4'b0000);
    assign is_read    = data_ram_enabled && (data_ram_write_enabled == 4'b0000);

    // Byte-lane RAM write; requests in a reset cycle are discarded.
    always_ff @(posedge clock) begin
        if (reset_n && is_write && !mmio_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (data_ram_write_enabled[i]) begin
                    mem[word_index][8*i +: 8] <= data_ram_write_data[8*i +: 8];
                end
            end
        end
    end

    // Read source select; RAM is read-first since it is sampled before the write edge.
    always_comb begin
        read_mux = 32'h0;
        if (mmio_hit) begin
            case (offset)
                OffTimer:   read_mux = timer_q;
                OffLed:     read_mux = {16'h0, led_q};
                OffNum:     read_mux = num_q;
                OffSwitch:  read_mux = {24'h0, sync2_q};
                OffScratch: read_mux = scratch_q;
                default:    read_mux = 32'h0;
            endcase
        end else begin
            read_mux = mem[word_index];
        end
    end

    // Next-state for MMIO registers, free-running timer and read data.
    always_comb begin
        timer_d     = timer_q + 32'd1;
        led_d       = led_q;
        num_d       = num_q;
        scratch_d   = scratch_q;
        read_data_d = read_data_q;
        if (is_read) begin
            read_data_d = read_mux;
        end
        if (is_write && mmio_hit) begin
            case (offset)
                // A timer write replaces that edge's increment.
                OffTimer: timer_d = merge_lanes(timer_q, data_ram_write_data,
                                                data_ram_write_enabled);
                OffLed: begin
                    if (data_ram_write_enabled[0]) led_d[7:0]  = data_ram_write_data[7:0];
                    if (data_ram_write_enabled[1]) led_d[15:8] = data_ram_write_data[15:8];
                end
                OffNum:     num_d = merge_lanes(num_q, data_ram_write_data,
                                                data_ram_write_enabled);
                OffScratch: scratch_d = merge_lanes(scratch_q, data_ram_write_data,
                                                    data_ram_write_enabled);
                default: ;
            endcase
        end
    end

    // State registers with synchronous active-low reset, plus the 2-flop switch synchronizer.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            timer_q     <= 32'h0;
            led_q       <= 16'h0;
            num_q       <= 32'h0;
            scratch_q   <= 32'h0;
            read_data_q <= 32'h0;
            sync1_q     <= 8'h0;
            sync2_q     <= 8'h0;
        end else begin
            timer_q     <= timer_d;
            led_q       <= led_d;
            num_q       <= num_d;
            scratch_q   <= scratch_d;
            read_data_q <= read_data_d;
            sync1_q     <= switch;
            sync2_q     <= sync1_q;
        end
    end

    assign data_ram_read_data = read_data_q;
    assign led                = led_q;
    assign num_display        = num_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench for data_ram_responder: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model.
module tb_data_ram_responder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        data_ram_enabled;
    logic [3:0]  data_ram_write_enabled;
    logic [31:0] data_ram_address;
    logic [31:0] data_ram_write_data;
    logic [31:0] data_ram_read_data;
    logic [7:0]  switch;
    logic [15:0] led;
    logic [31:0] num_display;

    data_ram_responder #(
        .RAM_ADDRESS_WIDTH(16),
        .MMIO_BASE        (32'hbfaf_0000)
    ) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .data_ram_enabled      (data_ram_enabled),
        .data_ram_write_enabled(data_ram_write_enabled),
        .data_ram_address      (data_ram_address),
        .data_ram_write_data   (data_ram_write_data),
        .data_ram_read_data    (data_ram_read_data),
        .switch                (switch),
        .led                   (led),
        .num_display           (num_display)
    );

    always #5 clock = ~clock;

    localparam logic [31:0] Mmio = 32'hbfaf_0000;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] ram_m [logic [15:0]];
    logic [31:0] t_base;     // timer value at cycle t_cyc; it then counts one per cycle
    int          t_cyc;
    int          cyc;        // number of clock edges seen so far
    logic [15:0] led_m;
    logic [31:0] num_m;
    logic [31:0] scratch_m;
    logic [31:0] rd_m;
    logic [7:0]  sw_hist [2]; // switch seen at the last edge and the one before
    logic [7:0]  sw_now = 8'h00;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_value,
                                          input logic [31:0] new_value,
                                          input logic [3:0]  mask);
        logic [31:0] r = old_value;
        for (int i = 0; i < 4; i++) if (mask[i]) r[8*i +: 8] = new_value[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] timer_now();
        return t_base + 32'(cyc - t_cyc);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [15:0] key = addr[17:2];
        if (addr[31:16] == Mmio[31:16]) begin
            case (addr[15:0])
                16'he000: return timer_now();
                16'hf000: return {16'h0, led_m};
                16'hf010: return num_m;
                16'hf020: return {24'h0, sw_hist[1]};
                16'hf030: return scratch_m;
                default:  return 32'h0;
            endcase
        end
        return ram_m.exists(key) ? ram_m[key] : 32'h0;
    endfunction

    // One clock cycle: drive a request, advance the model, then check all outputs.
    task automatic step(input logic rst_n, input logic en, input logic [3:0] mask,
                        input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] t_before = timer_now();
        logic [31:0] tmp;
        logic [15:0] key = addr[17:2];
        reset_n                = rst_n;
        data_ram_enabled       = en;
        data_ram_write_enabled = mask;
        data_ram_address       = addr;
        data_ram_write_data    = wdata;
        switch                 = sw_now;
        if (!rst_n) begin
            rd_m = 0; led_m = 0; num_m = 0; scratch_m = 0;
            t_base = 0; t_cyc = cyc + 1;
            sw_hist[0] = 0; sw_hist[1] = 0;
        end else begin
            if (en && mask == 4'h0) begin
                rd_m = model_read(addr);
            end else if (en) begin
                if (addr[31:16] == Mmio[31:16]) begin
                    case (addr[15:0])
                        16'he000: begin t_base = merge(t_before, wdata, mask); t_cyc = cyc + 1; end
                        16'hf000: begin tmp = merge({16'h0, led_m}, wdata, mask); led_m = tmp[15:0]; end
                        16'hf010: num_m = merge(num_m, wdata, mask);
                        16'hf030: scratch_m = merge(scratch_m, wdata, mask);
                        default: ;
                    endcase
                end else begin
                    ram_m[key] = merge(ram_m.exists(key) ? ram_m[key] : 32'h0, wdata, mask);
                end
            end
            sw_hist[1] = sw_hist[0];
            sw_hist[0] = sw_now;
        end
        @(posedge clock);
        cyc++;
        #1;
        chk("read_data", data_ram_read_data, rd_m);
        chk("led", {16'h0, led}, {16'h0, led_m});
        chk("num_display", num_display, num_m);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] addr);
        step(1'b1, 1'b1, 4'h0, addr, 32'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        step(1'b1, 1'b1, mask, addr, data);
    endtask

    logic [31:0] t1, t2, addr, wdata;
    logic [3:0]  mask;
    logic [15:0] offs [6] = '{16'he000, 16'hf000, 16'hf010, 16'hf020, 16'hf030, 16'hf040};

    initial begin
        cyc = 0; t_base = 0; t_cyc = 0;
        led_m = 0; num_m = 0; scratch_m = 0; rd_m = 0;
        sw_hist[0] = 0; sw_hist[1] = 0;

        // Reset with a write request that must be discarded.
        step(1'b0, 1'b1, 4'hf, 32'h0000_0100, 32'h1234_5678);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Timer starts at 0 in the first cycle after reset, then 1.
        rd(Mmio | 32'he000);
        chk("timer_first", data_ram_read_data, 32'h0);
        rd(Mmio | 32'he000);
        chk("timer_second", data_ram_read_data, 32'h1);

        // RAM byte lanes.
        wr(32'h0000_0100, 32'h1122_3344, 4'hf);
        wr(32'h0000_0100, 32'hAAAA_AAAA, 4'b0010);
        rd(32'h0000_0100);
        chk("ram_lanes", data_ram_read_data, 32'h1122_AA44);

        // Read immediately after write, plus address aliasing.
        wr(32'h0000_0200, 32'hDEAD_BEEF, 4'hf);
        rd(32'h0000_0200);
        chk("ram_raw", data_ram_read_data, 32'hDEAD_BEEF);
        rd(32'h0004_0200);
        chk("ram_alias", data_ram_read_data, 32'hDEAD_BEEF);

        // Timer counts one per cycle.
        rd(Mmio | 32'he000);
        t1 = data_ram_read_data;
        repeat (9) idle();
        rd(Mmio | 32'he000);
        t2 = data_ram_read_data;
        chk("timer_diff", t2 - t1, 32'd10);

        // Timer wrap.
        wr(Mmio | 32'he000, 32'hffff_fffe, 4'hf);
        idle();
        rd(Mmio | 32'he000);
        chk("timer_max", data_ram_read_data, 32'hffff_ffff);
        rd(Mmio | 32'he000);
        chk("timer_wrap", data_ram_read_data, 32'h0);

        // Partial timer write replaces that edge's increment.
        wr(Mmio | 32'he000, 32'h0000_1200, 4'hf);
        wr(Mmio | 32'he000, 32'h0000_0055, 4'b0001);
        rd(Mmio | 32'he000);
        chk("timer_merge", data_ram_read_data, 32'h0000_1255);

        // MMIO registers.
        wr(Mmio | 32'hf000, 32'hFFFF_1234, 4'hf);
        chk("led_write", {16'h0, led}, 32'h0000_1234);
        rd(Mmio | 32'hf000);
        chk("led_read", data_ram_read_data, 32'h0000_1234);
        wr(Mmio | 32'hf010, 32'h8765_4321, 4'hf);
        chk("num_write", num_display, 32'h8765_4321);
        wr(Mmio | 32'hf020, 32'hFFFF_FFFF, 4'hf);
        rd(Mmio | 32'hf020);
        chk("switch_ro", data_ram_read_data, 32'h0);
        rd(Mmio | 32'hf000);
        rd(Mmio | 32'hf040);
        chk("unmapped", data_ram_read_data, 32'h0);
        wr(Mmio | 32'hf030, 32'hCAFE_F00D, 4'hf);
        rd(Mmio | 32'hf030);
        chk("scratch", data_ram_read_data, 32'hCAFE_F00D);

        // Switch synchronizer delay.
        sw_now = 8'h5A;
        rd(Mmio | 32'hf020);
        chk("sw_edge0", data_ram_read_data, 32'h0);
        rd(Mmio | 32'hf020);
        chk("sw_edge1", data_ram_read_data, 32'h0);
        rd(Mmio | 32'hf020);
        chk("sw_edge2", data_ram_read_data, 32'h0000_005A);

        // Reset with a read in flight.
        rd(Mmio | 32'hf000);
        step(1'b0, 1'b1, 4'h0, Mmio | 32'hf000, 32'h0);
        chk("rst_read", data_ram_read_data, 32'h0);
        chk("rst_led", {16'h0, led}, 32'h0);
        chk("rst_num", num_display, 32'h0);

        // Random traffic over a pre-written RAM pool and the MMIO window.
        for (int k = 0; k < 8; k++) wr(32'h0000_0100 + 32'(k * 4), $urandom, 4'hf);
        for (int n = 0; n < 400; n++) begin
            sw_now = 8'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                addr = $urandom;
                addr[17:2] = 16'h0040 + 16'($urandom_range(0, 7));
            end else begin
                addr = {16'hbfaf, offs[$urandom_range(0, 5)]};
            end
            mask  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            wdata = $urandom;
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 5) != 0), mask, addr, wdata);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
